// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with latency-matched pixel output stage.
// Sync/de/colour lag x/y by PIX_LAT+1 en-cycles; display mode changes apply at frame boundaries.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 4,
  parameter int PIX_LAT  = 1
) (
  input  logic               dclk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [10:0]        x,
  output logic [10:0]        y,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
  localparam logic [10:0] HS_END = 11'(H_SYNC);
  localparam logic [10:0] VS_END = 11'(V_SYNC);
  localparam logic [10:0] HA0    = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HA1    = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] VA0    = 11'(V_SYNC + V_BP);
  localparam logic [10:0] VA1    = 11'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  localparam logic [COLOR_W-1:0] WIN_R  = COLOR_W'(0);
  localparam logic [COLOR_W-1:0] WIN_G  = COLOR_W'(7);
  localparam logic [COLOR_W-1:0] WIN_B  = COLOR_W'(1);
  localparam logic [COLOR_W-1:0] LOSE_R = COLOR_W'(15);
  localparam logic [COLOR_W-1:0] LOSE_G = COLOR_W'(1);
  localparam logic [COLOR_W-1:0] LOSE_B = COLOR_W'(0);

  logic [10:0] hc;
  logic [10:0] vc;
  logic        h_wrap;
  logic        v_wrap;
  logic        act_now;
  logic [1:0]  mode_q;

  // Raw timing flags carried down the alignment pipe: [2]=hsync active, [1]=vsync active, [0]=act
  logic [2:0]  s1;
  logic [2:0]  dly_out;

  logic [COLOR_W-1:0] red_next;
  logic [COLOR_W-1:0] green_next;
  logic [COLOR_W-1:0] blue_next;

  assign h_wrap  = (hc == H_LAST);
  assign v_wrap  = (vc == V_LAST);
  assign act_now = (hc >= HA0) && (hc < HA1) && (vc >= VA0) && (vc < VA1);

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (en) begin
      if (h_wrap) begin
        hc <= '0;
        vc <= v_wrap ? '0 : vc + 11'd1;
      end else begin
        hc <= hc + 11'd1;
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      s1          <= '0;
    end else if (en) begin
      x           <= act_now ? hc - HA0 : '0;
      y           <= act_now ? vc - VA0 : '0;
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
      s1          <= {hc < HS_END, vc < VS_END, act_now};
    end
  end

  // Shadowed so a mode write never tears the frame being scanned out
  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      mode_q <= 2'd3;
    end else if (en && h_wrap && v_wrap) begin
      mode_q <= mode;
    end
  end

  generate
    if (PIX_LAT == 0) begin : g_nodly
      assign dly_out = s1;
    end else begin : g_dly
      logic [2:0] sr [PIX_LAT];
      always_ff @(posedge dclk) begin
        if (!rst_n) begin
          for (int i = 0; i < PIX_LAT; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= s1;
          for (int i = 1; i < PIX_LAT; i++) sr[i] <= sr[i-1];
        end
      end
      assign dly_out = sr[PIX_LAT-1];
    end
  endgenerate

  always_comb begin
    red_next   = '0;
    green_next = '0;
    blue_next  = '0;
    if (dly_out[0]) begin
      case (mode_q)
        2'd0: begin
          red_next   = pix_r;
          green_next = pix_g;
          blue_next  = pix_b;
        end
        2'd1: begin
          red_next   = WIN_R;
          green_next = WIN_G;
          blue_next  = WIN_B;
        end
        2'd2: begin
          red_next   = LOSE_R;
          green_next = LOSE_G;
          blue_next  = LOSE_B;
        end
        default: begin
          red_next   = '0;
          green_next = '0;
          blue_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      hsync <= ~HS_ON;
      vsync <= ~VS_ON;
      de    <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (en) begin
      hsync <= dly_out[2] ? HS_ON : ~HS_ON;
      vsync <= dly_out[1] ? VS_ON : ~VS_ON;
      de    <= dly_out[0];
      red   <= red_next;
      green <= green_next;
      blue  <= blue_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two small-raster instances (latency 2 / active-low syncs, latency 0 / active-high syncs, 3-bit colour)
// checked every cycle against a position-index reference model.
module tb_vga_timing_gen;

  typedef struct {
    int ht; int vt; int hsw; int vsw;
    int ha0; int ha; int va0; int va;
    int lat; int hpol; int vpol; int cw;
  } prm_t;

  logic        dclk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;

  logic [3:0]  pr0, pg0, pb0, red0, grn0, blu0;
  logic [2:0]  pr1, pg1, pb1, red1, grn1, blu1;
  logic [10:0] x0, y0, x1, y1;
  logic        ls0, fs0, hs0, vs0, de0;
  logic        ls1, fs1, hs1, vs1, de1;

  int checks = 0;
  int errors = 0;

  // Model state: en-cycles since reset release, shadowed mode, expected registered colour
  int         n;
  logic [1:0] mq0, mq1;
  int         er0, eg0, eb0, er1, eg1, eb1;
  prm_t       P0, P1;

  always #5 dclk = ~dclk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(0), .VS_POL(0), .COLOR_W(4), .PIX_LAT(2)
  ) u_d0 (
    .dclk(dclk), .rst_n(rst_n), .en(en), .mode(mode),
    .pix_r(pr0), .pix_g(pg0), .pix_b(pb0),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0),
    .hsync(hs0), .vsync(vs0), .de(de0),
    .red(red0), .green(grn0), .blue(blu0)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1), .VS_POL(1), .COLOR_W(3), .PIX_LAT(0)
  ) u_d1 (
    .dclk(dclk), .rst_n(rst_n), .en(en), .mode(mode),
    .pix_r(pr1), .pix_g(pg1), .pix_b(pb1),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1),
    .hsync(hs1), .vsync(vs1), .de(de1),
    .red(red1), .green(grn1), .blue(blu1)
  );

  function automatic int frame_len(input prm_t P);
    return P.ht * P.vt;
  endfunction

  function automatic bit act_at(input prm_t P, input int p);
    int h = p % P.ht;
    int v = (p / P.ht) % P.vt;
    return (h >= P.ha0) && (h < P.ha0 + P.ha) && (v >= P.va0) && (v < P.va0 + P.va);
  endfunction

  function automatic int xcol(input prm_t P, input int p);
    return act_at(P, p) ? (p % P.ht) - P.ha0 : 0;
  endfunction

  function automatic int yrow(input prm_t P, input int p);
    return act_at(P, p) ? ((p / P.ht) % P.vt) - P.va0 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Pixel fed at the upcoming edge belongs to the position whose x/y was shown lat en-cycles earlier
  task automatic pix_gen(input prm_t P, output int r, output int g, output int b);
    int q = n - 1 - P.lat;
    int mask = (1 << P.cw) - 1;
    if (q >= 0 && act_at(P, q)) begin
      r = xcol(P, q) & mask;
      g = yrow(P, q) & mask;
    end else begin
      r = int'($urandom) & mask;
      g = int'($urandom) & mask;
    end
    b = int'($urandom) & mask;
  endtask

  task automatic col_exp(input prm_t P, input logic [1:0] mq, input int r, input int g, input int b,
                         output int er, output int eg, output int eb);
    int q = n - 1 - P.lat;
    int mask = (1 << P.cw) - 1;
    er = 0; eg = 0; eb = 0;
    if (q >= 0 && act_at(P, q)) begin
      case (mq)
        2'd0: begin er = r; eg = g; eb = b; end
        2'd1: begin er = 0; eg = 7 & mask; eb = 1 & mask; end
        2'd2: begin er = 15 & mask; eg = 1 & mask; eb = 0; end
        default: begin er = 0; eg = 0; eb = 0; end
      endcase
    end
  endtask

  task automatic check_dut(input string nm, input prm_t P,
                           input logic [10:0] ox, input logic [10:0] oy,
                           input logic ols, input logic ofs, input logic ohs, input logic ovs,
                           input logic ode, input logic [3:0] ored, input logic [3:0] ogrn,
                           input logic [3:0] oblu, input int er, input int eg, input int eb);
    int p = n - 1;
    int q = n - 2 - P.lat;
    bit hs_on = (q >= 0) && ((q % P.ht) < P.hsw);
    bit vs_on = (q >= 0) && (((q / P.ht) % P.vt) < P.vsw);
    bit hpol = (P.hpol != 0);
    bit vpol = (P.vpol != 0);
    chk({nm, "_x"}, 32'(ox), (n > 0) ? xcol(P, p) : 0);
    chk({nm, "_y"}, 32'(oy), (n > 0) ? yrow(P, p) : 0);
    chk({nm, "_line_start"}, 32'(ols), 32'((n > 0) && (p % P.ht == 0)));
    chk({nm, "_frame_start"}, 32'(ofs), 32'((n > 0) && (p % frame_len(P) == 0)));
    chk({nm, "_hsync"}, 32'(ohs), 32'(hs_on ? hpol : !hpol));
    chk({nm, "_vsync"}, 32'(ovs), 32'(vs_on ? vpol : !vpol));
    chk({nm, "_de"}, 32'(ode), 32'((q >= 0) && act_at(P, q)));
    chk({nm, "_red"}, 32'(ored), er);
    chk({nm, "_green"}, 32'(ogrn), eg);
    chk({nm, "_blue"}, 32'(oblu), eb);
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m);
    int r0, g0, b0, r1, g1, b1;
    rst_n = r;
    en    = e;
    mode  = m;
    pix_gen(P0, r0, g0, b0);
    pix_gen(P1, r1, g1, b1);
    pr0 = r0[3:0]; pg0 = g0[3:0]; pb0 = b0[3:0];
    pr1 = r1[2:0]; pg1 = g1[2:0]; pb1 = b1[2:0];
    if (!r) begin
      n = 0; mq0 = 2'd3; mq1 = 2'd3;
      er0 = 0; eg0 = 0; eb0 = 0; er1 = 0; eg1 = 0; eb1 = 0;
    end else if (e) begin
      col_exp(P0, mq0, r0, g0, b0, er0, eg0, eb0);
      col_exp(P1, mq1, r1, g1, b1, er1, eg1, eb1);
      if (n % frame_len(P0) == frame_len(P0) - 1) mq0 = m;
      if (n % frame_len(P1) == frame_len(P1) - 1) mq1 = m;
      n++;
    end
    @(posedge dclk);
    @(negedge dclk);
    check_dut("d0", P0, x0, y0, ls0, fs0, hs0, vs0, de0, red0, grn0, blu0, er0, eg0, eb0);
    check_dut("d1", P1, x1, y1, ls1, fs1, hs1, vs1, de1,
              {1'b0, red1}, {1'b0, grn1}, {1'b0, blu1}, er1, eg1, eb1);
  endtask

  initial begin
    int de0_cnt = 0, hs0_cnt = 0, vs0_cnt = 0, fs0_cnt = 0;
    int de1_cnt = 0, hs1_cnt = 0, vs1_cnt = 0;
    logic [1:0] m;

    P0 = '{ht: 28, vt: 15, hsw: 4, vsw: 2, ha0: 9, ha: 16, va0: 5, va: 8,
           lat: 2, hpol: 0, vpol: 0, cw: 4};
    P1 = '{ht: 17, vt: 10, hsw: 3, vsw: 1, ha0: 5, ha: 10, va0: 3, va: 6,
           lat: 0, hpol: 1, vpol: 1, cw: 3};
    n = 0; mq0 = 2'd3; mq1 = 2'd3;
    er0 = 0; eg0 = 0; eb0 = 0; er1 = 0; eg1 = 0; eb1 = 0;
    rst_n = 1'b0; en = 1'b0; mode = 2'd0;
    pr0 = '0; pg0 = '0; pb0 = '0; pr1 = '0; pg1 = '0; pb1 = '0;

    // Reset with en low and high, then free-run in pass-through with per-frame tallies
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 1040; i++) begin
      step(1'b1, 1'b1, 2'd0);
      if (n > frame_len(P0) && n <= 2 * frame_len(P0)) begin
        de0_cnt += int'(de0);
        hs0_cnt += int'(hs0 == 1'b0);
        vs0_cnt += int'(vs0 == 1'b0);
        fs0_cnt += int'(fs0);
      end
      if (n > frame_len(P1) && n <= 2 * frame_len(P1)) begin
        de1_cnt += int'(de1);
        hs1_cnt += int'(hs1 == 1'b1);
        vs1_cnt += int'(vs1 == 1'b1);
      end
    end
    chk("d0_de_per_frame", de0_cnt, P0.ha * P0.va);
    chk("d0_hsync_per_frame", hs0_cnt, P0.hsw * P0.vt);
    chk("d0_vsync_per_frame", vs0_cnt, P0.vsw * P0.ht);
    chk("d0_frame_start_per_frame", fs0_cnt, 1);
    chk("d1_de_per_frame", de1_cnt, P1.ha * P1.va);
    chk("d1_hsync_per_frame", hs1_cnt, P1.hsw * P1.vt);
    chk("d1_vsync_per_frame", vs1_cnt, P1.vsw * P1.ht);

    // Mid-frame switch to win colour, then a mid-frame reset
    for (int i = 0; i < 400; i++) step(1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 150; i++) step(1'b1, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 900; i++) step(1'b1, 1'b1, 2'd2);

    // Enable one cycle in four
    for (int i = 0; i < 1800; i++) step(1'b1, (i % 4) == 0, 2'd0);

    // Random enable, mode and occasional reset
    m = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) m = 2'($urandom_range(0, 3));
      step($urandom_range(0, 999) != 0, $urandom_range(0, 3) != 0, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
